// File: rtl/ame_num_approx_sched.sv
// Round-robin scheduler sharing one ame_num_approx unit among NUM_REQ requesters.
// One job in flight at a time; a watchdog turns a missing done into an error response.
module ame_num_approx_sched #(
  parameter int unsigned COMP_DATA_BITS = 64,
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYC    = 16,
  localparam int unsigned RES_BITS      = $clog2(COMP_DATA_BITS),
  localparam int unsigned ID_BITS       = $clog2(NUM_REQ)
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [NUM_REQ*COMP_DATA_BITS-1:0] req_data_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  output logic [ID_BITS-1:0]                rsp_id_o,
  output logic [RES_BITS-1:0]               rsp_data_o,
  output logic                              rsp_err_o,
  output logic                              comp_init_o,
  output logic [COMP_DATA_BITS-1:0]         comp_data_o,
  input  logic                              comp_done_i,
  input  logic [RES_BITS-1:0]               comp_data_i,
  output logic                              busy_o
);

  localparam int unsigned         WD_BITS = $clog2(TIMEOUT_CYC);
  localparam logic [WD_BITS-1:0]  WD_LAST = WD_BITS'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                      state;
  logic [ID_BITS-1:0]          ptr;
  logic [ID_BITS-1:0]          id_q;
  logic [WD_BITS-1:0]          wd;

  logic                        pick_found;
  logic [ID_BITS-1:0]          pick_id;
  logic [ID_BITS-1:0]          cand;
  logic [COMP_DATA_BITS-1:0]   pick_data;
  logic [ID_BITS-1:0]          ptr_next;

  // First valid requester searching from ptr upward, wrapping at NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_BITS'((32'(ptr) + i) % NUM_REQ);
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  assign pick_data = req_data_i[32'(pick_id)*COMP_DATA_BITS +: COMP_DATA_BITS];
  assign ptr_next  = ID_BITS'((32'(id_q) + 32'd1) % NUM_REQ);

  // comp_data_o doubles as the latched operand: loaded on grant, cleared on return to IDLE.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      id_q        <= '0;
      wd          <= '0;
      req_ready_o <= '0;
      rsp_valid_o <= '0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
      rsp_err_o   <= 1'b0;
      comp_init_o <= 1'b0;
      comp_data_o <= '0;
      busy_o      <= 1'b0;
    end else begin
      req_ready_o <= '0;
      rsp_valid_o <= '0;
      comp_init_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            req_ready_o <= NUM_REQ'(1) << pick_id;
            id_q        <= pick_id;
            comp_data_o <= pick_data;
            busy_o      <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          comp_init_o <= 1'b1;
          wd          <= '0;
          state       <= ST_WAIT;
        end
        ST_WAIT: begin
          // Done takes priority over a timeout landing in the same cycle.
          if (comp_done_i || (wd == WD_LAST)) begin
            rsp_valid_o <= NUM_REQ'(1) << id_q;
            rsp_id_o    <= id_q;
            rsp_data_o  <= comp_done_i ? comp_data_i : '0;
            rsp_err_o   <= !comp_done_i;
            ptr         <= ptr_next;
            comp_data_o <= '0;
            busy_o      <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            wd <= wd + WD_BITS'(1);
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
